fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. It replaces the fixed PC register, the PC+1 / branch adders and the next-PC mux chain of the single-cycle core with one block.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake with variable latency.
- Buffers returned instructions, tagged with their PCs, in a prefetch FIFO. Decode drains the FIFO over valid/ready.
- Applies branch (beq/bne-taken) and jump redirects with a FIFO flush and discard of any in-flight response.

Parameters:
- AW, 32: PC / instruction address width.
- DW, 32: instruction width.
- DEPTH, 4: prefetch FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 0: PC value loaded on reset.
- PC_INC, 4: sequential PC increment.
- BR_SHIFT, 2: left shift applied to the branch offset and the jump index.
- OFFW, 16: branch offset width (sign-extended).
- JW, 26: jump index width; AW >= JW+BR_SHIFT is required.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  AW  fetch address; stable while imem_req is high.
- imem_ack  in  1  transfer completes on any cycle with imem_req && imem_ack.
- imem_rdata  in  DW  instruction; valid only in the ack cycle.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  DW  head instruction.
- out_pc  out  AW  head PC.
- out_pc_inc  out  AW  out_pc+PC_INC.
- br_taken  in  1  redirect to the branch target (external branch&zero | bne&~zero).
- jmp_en  in  1  redirect to the jump target.
- br_base  in  AW  PC+PC_INC of the redirecting instruction.
- br_off  in  OFFW  branch offset.
- jmp_idx  in  JW  jump index.
- fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries.

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, FIFO empty, out_valid=0, fifo_count=0. Outputs clear immediately, without waiting for a clock edge.
- Redirect: redirect = jmp_en | br_taken. If both are high, jmp_en wins.
  - Jump target = {br_base[AW-1:JW+BR_SHIFT], jmp_idx, BR_SHIFT'b0}.
  - Branch target = br_base + (sext(br_off) << BR_SHIFT), modulo 2^AW.
  - All PC arithmetic wraps modulo 2^AW.
- FSM states: IDLE, REQ, DROP. imem_req and imem_addr are registered.
- IDLE:
  - If redirect: fetch_pc = target, stay IDLE.
  - Else if fifo_count < DEPTH, or a pop happens this cycle: go to REQ with imem_req=1, imem_addr=fetch_pc.
- REQ:
  - ack and no redirect: push {imem_rdata, imem_addr}, fetch_pc += PC_INC. If space remains after this cycle's push/pop, stay in REQ with imem_addr = new fetch_pc (throughput 1 per cycle with zero-wait memory). Otherwise go to IDLE with imem_req=0.
  - ack and redirect in the same cycle: discard the data, fetch_pc = target, go to IDLE.
  - No ack and redirect: fetch_pc = target, go to DROP with the request held and address unchanged.
  - No ack and no redirect: hold.
- DROP:
  - Keep the request high until ack; discard the returned data.
  - On ack, go to IDLE.
  - A redirect arriving in DROP overwrites fetch_pc and stays in DROP.
- Issue gating: at most one request is outstanding. A request is issued only when a FIFO slot is guaranteed, so a push can never overflow.
- FIFO:
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop at any occupancy, including full, is legal; count is unchanged.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
  - out_instr and out_pc come from the head entry; they are don't-care when out_valid=0.
- Flush: a redirect empties the FIFO at the same edge, so out_valid=0 in the next cycle. Any pop in the redirect cycle still completes for the decode stage.
- Latency: with an ack one cycle after req, the first out_valid occurs 3 cycles after reset deasserts.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, REQ, DROP}.
  - Functions br_target(base, off) and jmp_target(base, idx), parametrised by AW/OFFW/JW/BR_SHIFT.
- One sub-module, fetch_fifo: synchronous FIFO with parameters DEPTH and W=DW+AW, plus push, pop, flush, count, and head data outputs.

Test Plan:
- Reset with RESET_PC=0 and ack 1 cycle after req, out_ready=1 → out_pc sequence 0x0, 0x4, 0x8, 0xC, with out_instr = mem[0..3] and out_pc_inc = out_pc+4.
- out_ready=0 → fifo_count saturates at 4 and imem_req drops to 0. Raising out_ready → fetching resumes at 0x10 with no gaps or duplicates.
- br_taken=1, br_base=0x10, br_off=0xFFFE → FIFO flushed, next out_pc=0x08. jmp_en=1 in the same cycle instead → the jump target wins.
- jmp_en=1, br_base=0x10000004, jmp_idx=0x40 → next out_pc=0x10000100.
- Ack latency 3, redirect to 0x40 one cycle after req → the stale instruction never appears, req stays high until ack, next imem_addr=0x40.
- Drive rst low mid-REQ between clock edges → imem_req, out_valid and fifo_count clear immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and redirect-target arithmetic for the instruction-fetch front end.
// Targets are computed at a wide internal width and truncated by the caller to AW.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] wide_t;

  // base + (sext(off[offw-1:0]) << shift); the low AW bits wrap correctly.
  function automatic wide_t br_target(input wide_t base, input wide_t off,
                                      input int offw, input int shift);
    wide_t sext;
    sext = wide_t'($signed(off << (MAXW - offw)) >>> (MAXW - offw));
    return base + (sext << shift);
  endfunction

  // Upper bits of base kept above the index field, index placed above the zero shift bits.
  function automatic wide_t jmp_target(input wide_t base, input wide_t idx,
                                       input int jw, input int shift);
    wide_t mask;
    mask = (wide_t'(1) << (jw + shift)) - wide_t'(1);
    return (base & ~mask) | ((idx << shift) & mask);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} entries; flush empties it in one edge.
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a power of 2.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  entries [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) entries[wr_q] <= push_data;
  end

  assign head  = entries[rd_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding req/ack
// memory interface, buffers tagged instructions and applies branch/jump redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             PC_INC   = 4,
  parameter int             BR_SHIFT = 2,
  parameter int             OFFW     = 16,
  parameter int             JW       = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_ack,
  input  logic [DW-1:0]              imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_instr,
  output logic [AW-1:0]              out_pc,
  output logic [AW-1:0]              out_pc_inc,
  input  logic                       br_taken,
  input  logic                       jmp_en,
  input  logic [AW-1:0]              br_base,
  input  logic [OFFW-1:0]            br_off,
  input  logic [JW-1:0]              jmp_idx,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = DW + AW;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;

  logic          redirect, xfer, push, pop, room;
  logic [AW-1:0] target;
  logic [W-1:0]  head;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;

  assign redirect = jmp_en | br_taken;
  assign target   = jmp_en
                  ? AW'(jmp_target(wide_t'(br_base), wide_t'(jmp_idx), JW, BR_SHIFT))
                  : AW'(br_target(wide_t'(br_base), wide_t'(br_off), OFFW, BR_SHIFT));

  assign xfer = req_q & imem_ack;
  assign push = (state_q == REQ) & xfer & ~redirect;
  assign pop  = out_valid & out_ready;

  // A new request may only go out if its slot is free after this edge's push/pop.
  assign count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room        = count_after < (CW+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
        end else if (room) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (xfer && !redirect) begin
          fetch_pc_d = fetch_pc_q + AW'(PC_INC);
          if (room) begin
            addr_d = fetch_pc_d;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (xfer) begin
          fetch_pc_d = target;
          state_d    = IDLE;
          req_d      = 1'b0;
        end else if (redirect) begin
          // The bus request cannot be withdrawn; its data is dropped on arrival.
          fetch_pc_d = target;
          state_d    = DROP;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_d = target;
        if (xfer) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, addr_q}),
    .pop       (pop),
    .flush     (redirect),
    .valid     (out_valid),
    .head      (head),
    .count     (count)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign out_instr  = head[W-1:AW];
  assign out_pc     = head[AW-1:0];
  assign out_pc_inc = out_pc + AW'(PC_INC);
  assign fifo_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a variable-latency memory model, a program-order
// PC stream model feeding a scoreboard queue, and a monitor that checks every pop.
module tb_fetch_unit;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_inc;
  logic        br_taken, jmp_en;
  logic [31:0] br_base;
  logic [15:0] br_off;
  logic [25:0] jmp_idx;
  logic [2:0]  fifo_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  logic [31:0] exp_q [$];
  logic [31:0] tail;
  bit          pend;
  logic [31:0] pend_tgt;

  fetch_unit #(
    .AW(32), .DW(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(4),
    .BR_SHIFT(2), .OFFW(16), .JW(26)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc),
    .br_taken(br_taken), .jmp_en(jmp_en), .br_base(br_base), .br_off(br_off),
    .jmp_idx(jmp_idx), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Odd multiplier is a bijection, so every address holds a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] model_br(input logic [31:0] base, input logic [15:0] off);
    int o;
    o = int'($signed(off));
    return base + 32'(o * 4);
  endfunction

  function automatic logic [31:0] model_jmp(input logic [31:0] base, input logic [25:0] idx);
    return (base & 32'hF000_0000) | (32'(idx) * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
    tail = pc;
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    br_taken = 1'b0;
    jmp_en   = 1'b0;
    if (pend) begin
      restart_stream(pend_tgt);
      pend = 1'b0;
    end
    while (exp_q.size() < 16) begin
      tail = tail + 32'd4;
      exp_q.push_back(tail);
    end
  endtask

  task automatic do_branch(input logic [31:0] base, input logic [15:0] off);
    br_base  = base;
    br_off   = off;
    br_taken = 1'b1;
    pend     = 1'b1;
    pend_tgt = model_br(base, off);
  endtask

  task automatic do_jump(input logic [31:0] base, input logic [25:0] idx, input bit with_br);
    br_base  = base;
    jmp_idx  = idx;
    jmp_en   = 1'b1;
    br_taken = with_br;
    br_off   = 16'hFFFE;
    pend     = 1'b1;
    pend_tgt = model_jmp(base, idx);
  endtask

  // Assert reset between edges, check the immediate clear, then measure first-valid latency.
  task automatic do_reset();
    int n;
    #2;
    rst      = 1'b0;
    br_taken = 1'b0;
    jmp_en   = 1'b0;
    pend     = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    restart_stream(32'h0);
    lat = 1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check("first_valid_latency", n, 32'd3);
  endtask

  task automatic wait_head(input string name, input logic [31:0] exp);
    bit found;
    found     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        check(name, out_pc, exp);
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      lat       = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0:       do_branch($urandom, 16'($urandom));
          1:       do_jump($urandom, 26'($urandom), 1'b0);
          default: do_jump($urandom, 26'($urandom), 1'b1);
        endcase
      end
    end
  endtask

  // Memory model: ack once the request has waited `lat` cycles; data is a function of the address.
  initial begin : mem_model
    int wait_cnt;
    bit prev_req, prev_ack;
    wait_cnt   = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        wait_cnt = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        imem_ack = 1'b0;
      end else begin
        if (prev_req && prev_ack) wait_cnt = 0;
        else if (prev_req)        wait_cnt++;
        imem_ack   = imem_req && (wait_cnt >= lat);
        imem_rdata = mem_word(imem_addr);
        prev_req   = imem_req;
        prev_ack   = imem_ack;
      end
    end
  end

  // Monitor: every accepted head must be the next PC of the program-order stream.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e);
          check("sb_instr", out_instr, mem_word(e));
          check("sb_pc_inc", out_pc_inc, e + 32'd4);
        end
      end
    end
  end

  initial begin : stimulus
    bit seen;
    rst       = 1'b1;
    out_ready = 1'b0;
    br_taken  = 1'b0;
    jmp_en    = 1'b0;
    br_base   = '0;
    br_off    = '0;
    jmp_idx   = '0;
    pend      = 1'b0;
    restart_stream(32'h0);

    do_reset();

    // Back-pressure: FIFO fills to DEPTH and fetching stops, then resumes at 0x10.
    repeat (12) step();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req_low", 32'(imem_req), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    repeat (20) step();

    random_phase(300);

    // Backward branch flushes and restarts at 0x8.
    out_ready = 1'b1;
    lat       = 0;
    step();
    do_branch(32'h10, 16'hFFFE);
    step();
    check("br_flush_valid", 32'(out_valid), 32'd0);
    check("br_flush_count", 32'(fifo_count), 32'd0);
    wait_head("br_target", 32'h8);

    // Jump and branch together: the jump target wins.
    step();
    do_jump(32'h10, 26'h40, 1'b1);
    step();
    check("both_flush_valid", 32'(out_valid), 32'd0);
    wait_head("jmp_wins", 32'h100);

    step();
    do_jump(32'h1000_0004, 26'h40, 1'b0);
    step();
    wait_head("jmp_target", 32'h1000_0100);

    // Redirect while a slow request is outstanding: request held, data dropped.
    out_ready = 1'b0;
    lat       = 3;
    repeat (25) step();
    do_jump(32'h0, 26'h80, 1'b0);
    step();
    step();
    step();
    check("drop_req_issue", 32'(imem_req), 32'd1);
    check("drop_addr_issue", imem_addr, 32'h200);
    do_branch(32'h40, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      check("drop_req_held", 32'(imem_req), 32'd1);
      check("drop_addr_held", imem_addr, 32'h200);
      if (imem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("drop_ack_timeout", 32'd0, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_req) begin
        check("drop_next_addr", imem_addr, 32'h40);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("drop_next_timeout", 32'd0, 32'd1);
    wait_head("drop_next_head", 32'h40);

    random_phase(300);

    // Asynchronous reset in the middle of a request.
    out_ready = 1'b1;
    lat       = 2;
    seen      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("mid_req_timeout", 32'd0, 32'd1);
    do_reset();
    out_ready = 1'b1;
    repeat (20) step();

    random_phase(200);
    out_ready = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
